// File: rtl/latch_acq_sequencer_if.sv
// rtl/latch_acq_sequencer_if.sv - readout stream bundle between the acquisition sequencer and the FIFO path
interface latch_acq_sequencer_if #(
    parameter int WIDTH = 12,
    parameter int CH_W  = 2
);
    logic [WIDTH-1:0] out_data;
    logic [CH_W-1:0]  out_ch;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_ch, output out_valid, input out_ready);
    modport slave  (input out_data, input out_ch, input out_valid, output out_ready);
endinterface

// File: rtl/latch_acq_sequencer.sv
// rtl/latch_acq_sequencer.sv - trigger -> peaking delay -> latch strobe -> channel readout -> dead time
// Optional lost-trigger counter enabled by defining LATCH_SEQ_LOST_CNT_EN.
module latch_acq_sequencer #(
    parameter int WIDTH       = 12,
    parameter int N_CH        = 4,
    parameter int DLY_W       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  trigger_i,
    input  logic [DLY_W-1:0]      delay_cfg_i,
    input  logic [DLY_W-1:0]      dead_cfg_i,
    input  logic [N_CH*WIDTH-1:0] latch_data_i,
    output logic                  update_flag_o,
    output logic                  busy_o,
    output logic [15:0]           event_count_o,
    latch_acq_sequencer_if.master rd
`ifdef LATCH_SEQ_LOST_CNT_EN
    ,
    output logic [15:0]           lost_count_o
`endif
);
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_LATCH,
        S_SETTLE,
        S_SEND,
        S_DEAD
    } state_t;

    state_t            state_q, state_d;
    logic [DLY_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CH_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [15:0]       evt_q, evt_d;
    logic              upd_q, upd_d;
    logic              valid_q, valid_d;
    logic              busy_q;
    logic              trig_q;

    logic              edge_w;
    logic [CH_W-1:0]   idx_inc;
    logic [CH_W-1:0]   sel_w;
    logic [WIDTH-1:0]  word_w;

    assign edge_w  = trigger_i & ~trig_q;
    assign idx_inc = idx_q + CH_W'(1);

    // The word loaded next is ch0 on entry to SEND, otherwise the one after idx_q.
    assign sel_w  = (state_q == S_SEND) ? idx_inc : '0;
    assign word_w = latch_data_i[sel_w*WIDTH +: WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        data_d  = data_q;
        evt_d   = evt_q;
        upd_d   = upd_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (edge_w) begin
                    state_d = S_DELAY;
                    cnt_d   = delay_cfg_i;
                end
            end
            S_DELAY: begin
                if (cnt_q == '0) begin
                    state_d = S_LATCH;
                    upd_d   = 1'b1;
                    hold_d  = HOLD_W'(HOLD_CYCLES - 1);
                    evt_d   = evt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q - DLY_W'(1);
                end
            end
            S_LATCH: begin
                if (hold_q == '0) begin
                    state_d = S_SETTLE;
                    upd_d   = 1'b0;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            S_SETTLE: begin
                state_d = S_SEND;
                idx_d   = '0;
                valid_d = 1'b1;
                data_d  = word_w;
            end
            S_SEND: begin
                if (valid_q && rd.out_ready) begin
                    if (idx_q == CH_W'(N_CH - 1)) begin
                        state_d = S_DEAD;
                        valid_d = 1'b0;
                        cnt_d   = dead_cfg_i;
                    end else begin
                        idx_d  = idx_inc;
                        data_d = word_w;
                    end
                end
            end
            S_DEAD: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - DLY_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            evt_q   <= '0;
            upd_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            evt_q   <= evt_d;
            upd_q   <= upd_d;
            valid_q <= valid_d;
            busy_q  <= (state_d != S_IDLE);
            trig_q  <= trigger_i;
        end
    end

`ifdef LATCH_SEQ_LOST_CNT_EN
    logic [15:0] lost_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lost_q <= '0;
        end else if (edge_w && (state_q != S_IDLE) && (lost_q != 16'hFFFF)) begin
            lost_q <= lost_q + 16'd1;
        end
    end

    assign lost_count_o = lost_q;
`endif

    assign update_flag_o = upd_q;
    assign busy_o        = busy_q;
    assign event_count_o = evt_q;
    assign rd.out_data   = data_q;
    assign rd.out_ch     = idx_q;
    assign rd.out_valid  = valid_q;
endmodule
